// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressable data memory.
// Covers access-size encoding, the clear/ready states, byte-enable masks and alignment checks.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_e;

    // Lane is zero-extended to 3 bits so one helper serves 32- and 64-bit words.
    function automatic logic [7:0] byte_en_mask(mem_size_e size, logic [2:0] lane);
        logic [7:0] base;
        case (size)
            MEM_B:   base = 8'h01;
            MEM_H:   base = 8'h03;
            MEM_W:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << lane;
    endfunction

    function automatic logic is_misaligned(mem_size_e size, logic [2:0] lane,
                                           logic [1:0] word_bytes_pow);
        logic off;
        case (size)
            MEM_B:   off = 1'b0;
            MEM_H:   off = lane[0];
            MEM_W:   off = |lane[1:0];
            default: off = |lane;
        endcase
        return off | (2'(size) > word_bytes_pow);
    endfunction

endpackage

// File: rtl/byte_data_memory_if.sv
// Request/response bus of the MEM-stage data memory.
// The master drives load/store requests; the slave returns the registered response.
interface byte_data_memory_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                  memRead_ctrl;
    logic                  memWrite_ctrl;
    logic [1:0]            size_in;
    logic                  unsigned_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  misaligned_out;

    modport master (
        output memRead_ctrl, memWrite_ctrl, size_in, unsigned_in, addr_in, data_in,
        input  req_ready, rsp_valid, data_out, misaligned_out
    );

    modport slave (
        input  memRead_ctrl, memWrite_ctrl, size_in, unsigned_in, addr_in, data_in,
        output req_ready, rsp_valid, data_out, misaligned_out
    );
endinterface

// File: rtl/dmem_load_extend.sv
// Combinational load formatter: picks the addressed bytes out of a word,
// right-aligns them and sign- or zero-extends to the full data width.
module dmem_load_extend
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int OFFS_W     = 3
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [OFFS_W-1:0]     lane_i,
    input  mem_size_e             size_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep;
    logic                  sign;

    always_comb begin
        shifted = word_i >> {lane_i, 3'b000};
        case (size_i)
            MEM_B: begin
                keep = DATA_WIDTH'(64'h0000_0000_0000_00FF);
                sign = shifted[7];
            end
            MEM_H: begin
                keep = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
                sign = shifted[15];
            end
            MEM_W: begin
                keep = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                keep = '1;
                sign = shifted[DATA_WIDTH-1];
            end
        endcase
        data_o = (shifted & keep) | (~keep & {DATA_WIDTH{sign & ~unsigned_i}});
    end
endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable data memory with B/H/W/D access, misalignment faults and a 1-cycle read.
// Define DMEM_CLEAR_ON_RESET_EN to zero the whole array after reset before accepting requests.
module byte_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH_POW = 6,
    parameter int ADDR_WIDTH_POW = 6,
    parameter int MEM_DEPTH_POW  = 12
) (
    input  logic          clk_in,
    input  logic          reset,
    byte_data_memory_if.slave bus
);
    localparam int DATA_WIDTH = 1 << DATA_WIDTH_POW;
    localparam int ADDR_WIDTH = 1 << ADDR_WIDTH_POW;
    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int OFFS_W     = DATA_WIDTH_POW - 3;
    localparam int MEM_DEPTH  = 1 << MEM_DEPTH_POW;

    logic [DATA_WIDTH-1:0]    mem_q [MEM_DEPTH];
    dmem_state_e              state_q, state_d;
    logic [MEM_DEPTH_POW-1:0] word_idx;
    logic [OFFS_W-1:0]        lane;
    logic [2:0]               lane3;
    mem_size_e                size;
    logic [7:0]               be_all;
    logic [WORD_BYTES-1:0]    be;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH-1:0]    ld_data;
    logic                     fault, accept, wr_en;
    logic                     rsp_q, rsp_d, mis_q, mis_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     unused_addr_hi;

    assign word_idx       = bus.addr_in[OFFS_W +: MEM_DEPTH_POW];
    assign lane           = bus.addr_in[OFFS_W-1:0];
    assign lane3          = 3'(lane);
    assign size           = mem_size_e'(bus.size_in);
    assign unused_addr_hi = ^bus.addr_in[ADDR_WIDTH-1:OFFS_W+MEM_DEPTH_POW];
    assign fault          = is_misaligned(size, lane3, 2'(OFFS_W));
    assign be_all         = byte_en_mask(size, lane3);
    assign be             = be_all[WORD_BYTES-1:0];
    assign wdata          = bus.data_in << {lane, 3'b000};

    assign bus.req_ready  = (state_q == READY);
    assign accept         = (bus.memRead_ctrl | bus.memWrite_ctrl) & bus.req_ready & ~reset;
    assign wr_en          = accept & bus.memWrite_ctrl & ~fault;
    // A store wins over a simultaneous load; only its fault produces a response.
    assign rsp_d          = accept & (fault | ~bus.memWrite_ctrl);
    assign mis_d          = rsp_d & fault;
    assign data_d         = rsp_d ? (fault ? '0 : ld_data) : data_q;

    dmem_load_extend #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFFS_W     (OFFS_W)
    ) u_load_extend (
        .word_i     (mem_q[word_idx]),
        .lane_i     (lane),
        .size_i     (size),
        .unsigned_i (bus.unsigned_in),
        .data_o     (ld_data)
    );

`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [MEM_DEPTH_POW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + MEM_DEPTH_POW'(1);
                if (cnt_q == '1) state_d = READY;
            end
            default: ;
        endcase
    end
`else
    always_ff @(posedge clk_in) begin
        if (reset) state_q <= READY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
    end
`endif

    always_ff @(posedge clk_in) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (state_q == CLEAR) mem_q[cnt_q] <= '0;
        else
`endif
        if (wr_en) begin
            for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) mem_q[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rsp_q  <= 1'b0;
            mis_q  <= 1'b0;
            data_q <= '0;
        end else begin
            rsp_q  <= rsp_d;
            mis_q  <= mis_d;
            data_q <= data_d;
        end
    end

    assign bus.rsp_valid      = rsp_q;
    assign bus.misaligned_out = mis_q;
    assign bus.data_out       = data_q;
endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: byte-array reference model, per-cycle output compare,
// directed cases with literal expectations and a randomized request phase.
module tb_byte_data_memory;
    localparam int DWP   = 6;
    localparam int AWP   = 6;
    localparam int MDP   = 4;
    localparam int DW    = 1 << DWP;
    localparam int AW    = 1 << AWP;
    localparam int DEPTH = 1 << MDP;
    localparam int WB    = DW / 8;
`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam int EXP_LOW = DEPTH;
`else
    localparam int EXP_LOW = 0;
`endif

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    byte_data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    byte_data_memory #(
        .DATA_WIDTH_POW (DWP),
        .ADDR_WIDTH_POW (AWP),
        .MEM_DEPTH_POW  (MDP)
    ) dut (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus)
    );

    logic [7:0]    mm [DEPTH*WB];
    bit            exp_ready, exp_rsp, exp_mis;
    logic [DW-1:0] exp_data;
    int            clear_left;
    bit            chk_en;
    int            n_cmp, n_err;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, outputs derived from the access rules.
    task automatic model_edge();
        int nb, lane, word;
        bit fault, acc;
        logic [DW-1:0] v;
        if (rst) begin
            exp_rsp  = 1'b0;
            exp_mis  = 1'b0;
            exp_data = '0;
`ifdef DMEM_CLEAR_ON_RESET_EN
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH*WB; i++) mm[i] = 8'h00;
`endif
        end else begin
            acc     = (bus.memRead_ctrl || bus.memWrite_ctrl) && exp_ready;
            exp_rsp = 1'b0;
            exp_mis = 1'b0;
            if (acc) begin
                nb    = 1 << bus.size_in;
                lane  = int'(bus.addr_in % 64'(WB));
                word  = int'((bus.addr_in / 64'(WB)) % 64'(DEPTH));
                fault = (nb > WB) || (lane % nb != 0);
                if (fault) begin
                    exp_rsp  = 1'b1;
                    exp_mis  = 1'b1;
                    exp_data = '0;
                end else if (bus.memWrite_ctrl) begin
                    for (int i = 0; i < nb; i++)
                        mm[word*WB + lane + i] = 8'(bus.data_in >> (8*i));
                end else begin
                    v = '0;
                    for (int i = 0; i < nb; i++)
                        v = v | (DW'(mm[word*WB + lane + i]) << (8*i));
                    if (!bus.unsigned_in && nb < WB && v[8*nb-1])
                        v = v | ({DW{1'b1}} << (8*nb));
                    exp_rsp  = 1'b1;
                    exp_data = v;
                end
            end
            if (clear_left > 0) clear_left--;
        end
        exp_ready = (clear_left == 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
            check("misaligned", 64'(bus.misaligned_out), 64'(exp_mis));
            check("data_out", bus.data_out, exp_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.memRead_ctrl  = 1'b0;
        bus.memWrite_ctrl = 1'b0;
    endtask

    task automatic drive(bit rd, bit wr, logic [1:0] sz, bit u, logic [63:0] a, logic [63:0] d);
        bus.memRead_ctrl  = rd;
        bus.memWrite_ctrl = wr;
        bus.size_in       = sz;
        bus.unsigned_in   = u;
        bus.addr_in       = a;
        bus.data_in       = d;
    endtask

    task automatic req(bit rd, bit wr, logic [1:0] sz, bit u, logic [63:0] a, logic [63:0] d);
        drive(rd, wr, sz, u, a, d);
        tick();
        idle();
    endtask

    task automatic lit(string nm, bit r, bit m, logic [63:0] d);
        @(negedge clk);
        #1;
        check({nm, "_rsp"}, 64'(bus.rsp_valid), 64'(r));
        check({nm, "_mis"}, 64'(bus.misaligned_out), 64'(m));
        check({nm, "_data"}, bus.data_out, d);
    endtask

    task automatic wait_ready(string nm);
        int low;
        low = 0;
        while (!bus.req_ready && low < 40) begin
            low++;
            tick();
        end
        check(nm, 64'(low), 64'(EXP_LOW));
    endtask

    initial begin
        logic [63:0] a, d;
        bit rd, wr;
        logic [1:0] sz;
        n_cmp = 0;
        n_err = 0;
        chk_en = 1'b0;
        clear_left = 0;
        exp_ready = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready("ready_low_cycles");

`ifdef DMEM_CLEAR_ON_RESET_EN
        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h78, '0);
        lit("ld_after_clear", 1'b1, 1'b0, 64'h0);
`else
        for (int w = 0; w < DEPTH; w++)
            req(1'b0, 1'b1, 2'd3, 1'b0, 64'(w*8), {$urandom, $urandom});
`endif

        req(1'b0, 1'b1, 2'd3, 1'b0, 64'h10, 64'h8877665544332211);
        req(1'b0, 1'b1, 2'd0, 1'b0, 64'h13, 64'h00000000000000AA);
        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, '0);
        lit("ld_10", 1'b1, 1'b0, 64'h88776655AA332211);
        req(1'b1, 1'b0, 2'd0, 1'b0, 64'h13, '0);
        lit("lb_13", 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFAA);
        req(1'b1, 1'b0, 2'd0, 1'b1, 64'h13, '0);
        lit("lbu_13", 1'b1, 1'b0, 64'h00000000000000AA);
        req(1'b1, 1'b0, 2'd1, 1'b0, 64'h12, '0);
        lit("lh_12", 1'b1, 1'b0, 64'hFFFFFFFFFFFFAA33);
        req(1'b1, 1'b0, 2'd2, 1'b1, 64'h14, '0);
        lit("lwu_14", 1'b1, 1'b0, 64'h0000000088776655);

        req(1'b0, 1'b1, 2'd2, 1'b0, 64'h06, 64'hDEADBEEF);
        lit("sw_06_fault", 1'b1, 1'b1, 64'h0);
        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h00, '0);
        req(1'b1, 1'b0, 2'd1, 1'b0, 64'h11, '0);
        lit("lh_11_fault", 1'b1, 1'b1, 64'h0);

        req(1'b1, 1'b1, 2'd3, 1'b0, 64'h20, 64'h0123456789ABCDEF);
        lit("both_hi", 1'b0, 1'b0, 64'h0);
        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h20, '0);
        lit("ld_20", 1'b1, 1'b0, 64'h0123456789ABCDEF);

        req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10 + 64'(DEPTH*8), '0);
        lit("ld_wrap", 1'b1, 1'b0, 64'h88776655AA332211);

        drive(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, '0);
        tick();
        drive(1'b1, 1'b0, 2'd3, 1'b0, 64'h18, '0);
        tick();
        idle();
        tick();

        drive(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, '0);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'd3, 1'b0, 64'h18, '0);
        tick();
        rst = 1'b0;
        idle();
        lit("rst_drops_rsp", 1'b0, 1'b0, 64'h0);
        wait_ready("ready_low_after_rst");

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 99) == 0) begin
                idle();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                wait_ready("ready_low_rand_rst");
            end
            rd = $urandom_range(0, 1) == 1;
            wr = $urandom_range(0, 3) == 0;
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            d  = {$urandom, $urandom};
            drive(rd, wr, sz, $urandom_range(0, 1) == 1, a, d);
            tick();
        end
        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
